// File: rtl/seq_match_pkg.sv
// Shared constants and the masked-compare helper for the streaming pattern matcher.
package seq_match_pkg;

    // Default build: match the ASCII word "HELLO" coming from a byte source.
    localparam int DEF_DATA_W  = 8;
    localparam int DEF_PAT_LEN = 5;
    localparam int DEF_CNT_W   = 16;
    localparam logic [DEF_PAT_LEN*DEF_DATA_W-1:0] DEF_PATTERN = "HELLO";

    // Widest history the compare helper accepts. Callers zero-extend their
    // history, pattern and mask to this width so one function serves every
    // parameterisation.
    localparam int MAX_BITS = 1024;

    typedef logic [MAX_BITS-1:0] cmp_vec_t;

    // True when every bit selected by mask agrees between hist and pat.
    // mask is already expanded from per-symbol to per-bit form.
    function automatic logic mask_eq(input cmp_vec_t hist,
                                     input cmp_vec_t pat,
                                     input cmp_vec_t mask);
        return ((hist ^ pat) & mask) == '0;
    endfunction

endpackage

// File: rtl/seq_match_hist.sv
// Symbol history shift register plus saturating fill counter.
// Exposes the next-state history and a "full after this symbol" flag so the
// parent can evaluate a hit in the same cycle the final symbol arrives.
module seq_match_hist
    import seq_match_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int PAT_LEN = DEF_PAT_LEN
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      shift_i,
    input  logic [DATA_W-1:0]         sym_i,
    input  logic                      sync_zero_i,
    output logic [PAT_LEN*DATA_W-1:0] hist_nx_o,
    output logic                      full_nx_o
);
    localparam int HW = PAT_LEN * DATA_W;
    localparam int FW = $clog2(PAT_LEN + 1);
    localparam logic [FW-1:0] FILL_MAX = FW'(PAT_LEN);

    logic [HW-1:0] hist_q, hist_d;
    logic [FW-1:0] fill_q, fill_inc, fill_d;

    // Advance history and fill counter when a symbol is accepted.
    always_comb begin
        hist_d   = hist_q;
        fill_inc = fill_q;
        if (shift_i) begin
            // Newest symbol enters the low slot; the oldest falls off the top.
            hist_d = (hist_q << DATA_W) | HW'(sym_i);
            if (fill_q != FILL_MAX) begin
                fill_inc = fill_q + 1'b1;
            end
        end
    end

    // sync_zero is kept out of the outputs' cone so the parent's hit logic
    // can feed it back without forming a combinational loop.
    assign fill_d    = sync_zero_i ? '0 : fill_inc;
    assign hist_nx_o = hist_d;
    assign full_nx_o = (fill_inc == FILL_MAX);

    // History and fill state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hist_q <= '0;
            fill_q <= '0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
        end
    end

endmodule

// File: rtl/seq_matcher.sv
// Streaming pattern detector: compares the last PAT_LEN accepted symbols
// against PATTERN (with per-slot don't-cares) and reports each detection as
// a one-cycle pulse, an LED toggle and a saturating count.
module seq_matcher
    import seq_match_pkg::*;
#(
    parameter int                        DATA_W  = DEF_DATA_W,
    parameter int                        PAT_LEN = DEF_PAT_LEN,
    parameter logic [PAT_LEN*DATA_W-1:0] PATTERN = DEF_PATTERN,
    parameter logic [PAT_LEN-1:0]        MASK    = '1,
    parameter bit                        OVERLAP = 1'b1,
    parameter int                        CNT_W   = DEF_CNT_W
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              data_valid,
    input  logic [DATA_W-1:0] data,
    input  logic              clear,
    output logic              match,
    output logic              led,
    output logic [CNT_W-1:0]  match_cnt
);
    localparam int HW = PAT_LEN * DATA_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             accept;
    logic             full_nx;
    logic             hit;
    logic             sync_zero;
    logic [HW-1:0]    hist_nx;
    logic [HW-1:0]    bitmask;
    cmp_vec_t         hist_ext, pat_ext, mask_ext;
    logic             match_q, match_d;
    logic             led_q, led_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // clear wins over a symbol presented in the same cycle.
    assign accept = data_valid & ~clear;

    // Restart detection on clear, and after every hit when matches may not
    // share symbols.
    assign sync_zero = clear | (hit & ~OVERLAP);

    seq_match_hist #(
        .DATA_W  (DATA_W),
        .PAT_LEN (PAT_LEN)
    ) u_hist (
        .clk_i       (Clk),
        .rst_ni      (Rst),
        .shift_i     (accept),
        .sym_i       (data),
        .sync_zero_i (sync_zero),
        .hist_nx_o   (hist_nx),
        .full_nx_o   (full_nx)
    );

    // Expand the per-symbol mask to a per-bit mask.
    for (genvar i = 0; i < PAT_LEN; i++) begin : g_mask
        assign bitmask[i*DATA_W +: DATA_W] = {DATA_W{MASK[i]}};
    end

    // Zero-extend operands to the helper's fixed width.
    always_comb begin
        hist_ext         = '0;
        pat_ext          = '0;
        mask_ext         = '0;
        hist_ext[HW-1:0] = hist_nx;
        pat_ext[HW-1:0]  = PATTERN;
        mask_ext[HW-1:0] = bitmask;
    end

    // A hit is judged on the history as it will be after this symbol, so the
    // pulse appears in the cycle right after the final symbol is presented.
    assign hit = accept & full_nx & mask_eq(hist_ext, pat_ext, mask_ext);

    // Next-state for the pulse, LED and saturating counter.
    always_comb begin
        match_d = hit;
        led_d   = led_q;
        cnt_d   = cnt_q;
        if (clear) begin
            match_d = 1'b0;
            cnt_d   = '0;
        end else if (hit) begin
            led_d = ~led_q;
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Output registers; the LED idles lit out of reset.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            match_q <= 1'b0;
            led_q   <= 1'b1;
            cnt_q   <= '0;
        end else begin
            match_q <= match_d;
            led_q   <= led_d;
            cnt_q   <= cnt_d;
        end
    end

    assign match     = match_q;
    assign led       = led_q;
    assign match_cnt = cnt_q;

endmodule
